// File: rtl/cos_job_issuer.sv
// cos_job_issuer: queues (x,y) cosine jobs and issues them one at a time to a cosine core
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_x/req_y    job offer; accepted when req_valid && req_ready
//   req_ready                job queue not full
//   core_start               one-cycle start pulse to the core
//   core_x/core_y            operands held from start until completion
//   core_ready/core_result   core completion level and result
//   res_valid/res_data       captured result, held until res_ack
//   res_ack                  downstream consumes the result
//   busy                     FSM not idle or queue non-empty
//   done_count               completed jobs, wrapping
//   res_err                  only with COS_ISSUER_TIMEOUT_EN: result came from the watchdog
// Define COS_ISSUER_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog.
module cos_job_issuer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [9:0] req_x,
    input  logic [7:0] req_y,
    output logic       req_ready,
    output logic       core_start,
    output logic [9:0] core_x,
    output logic [7:0] core_y,
    input  logic       core_ready,
    input  logic [9:0] core_result,
    output logic       res_valid,
    output logic [9:0] res_data,
    input  logic       res_ack,
    output logic       busy,
    output logic [7:0] done_count
`ifdef COS_ISSUER_TIMEOUT_EN
    ,
    output logic       res_err
`endif
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, HOLD} state_t;
    state_t        state_q, state_d;
    logic [17:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          core_start_q, core_start_d;
    logic [9:0]    core_x_q, core_x_d;
    logic [7:0]    core_y_q, core_y_d;
    logic          res_valid_q, res_valid_d;
    logic [9:0]    res_data_q, res_data_d;
    logic [7:0]    done_count_q, done_count_d;
    logic          push, pop;
`ifdef COS_ISSUER_TIMEOUT_EN
    logic [15:0]   tmo_q, tmo_d;
    logic          res_err_q, res_err_d;
    logic          tmo_hit;
`else
    logic          tmo_unused;
    assign tmo_unused = |TIMEOUT_CYCLES;
`endif

    assign req_ready  = count_q != (AW+1)'(FIFO_DEPTH);
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign core_start = core_start_q;
    assign core_x     = core_x_q;
    assign core_y     = core_y_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign done_count = done_count_q;
`ifdef COS_ISSUER_TIMEOUT_EN
    assign res_err    = res_err_q;
`endif

    always_comb begin
        push         = req_valid && req_ready;
        // count_q is registered, so a job written this cycle is only visible to IDLE next cycle
        pop          = (state_q == IDLE) && (count_q != '0);
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
        state_d      = state_q;
        core_start_d = 1'b0;
        core_x_d     = core_x_q;
        core_y_d     = core_y_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        done_count_d = done_count_q;
`ifdef COS_ISSUER_TIMEOUT_EN
        res_err_d    = res_err_q;
        tmo_d        = (state_q == ARM || state_q == WAIT) ? tmo_q + 16'd1 : 16'd0;
        tmo_hit      = (state_q == ARM || state_q == WAIT) && (tmo_q == 16'(TIMEOUT_CYCLES - 1));
`endif
        case (state_q)
            IDLE: begin
                if (pop) begin
                    {core_x_d, core_y_d} = mem_q[rd_ptr_q];
                    core_start_d         = 1'b1;
                    state_d              = ISSUE;
                end
            end
            ISSUE: state_d = ARM;
            // ready still high from the previous job must drop before a completion counts
            ARM: state_d = core_ready ? ARM : WAIT;
            WAIT: begin
                if (core_ready) begin
                    res_data_d   = core_result;
                    res_valid_d  = 1'b1;
                    done_count_d = done_count_q + 8'd1;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (res_ack) begin
                    res_valid_d = 1'b0;
`ifdef COS_ISSUER_TIMEOUT_EN
                    res_err_d   = 1'b0;
`endif
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef COS_ISSUER_TIMEOUT_EN
        // a genuine completion in the same cycle wins over the watchdog
        if (tmo_hit && state_d != HOLD) begin
            res_data_d  = 10'h3FF;
            res_valid_d = 1'b1;
            res_err_d   = 1'b1;
            state_d     = HOLD;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_x, req_y};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            core_start_q <= 1'b0;
            core_x_q     <= '0;
            core_y_q     <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            done_count_q <= '0;
`ifdef COS_ISSUER_TIMEOUT_EN
            tmo_q        <= '0;
            res_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            core_start_q <= core_start_d;
            core_x_q     <= core_x_d;
            core_y_q     <= core_y_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            done_count_q <= done_count_d;
`ifdef COS_ISSUER_TIMEOUT_EN
            tmo_q        <= tmo_d;
            res_err_q    <= res_err_d;
`endif
        end
    end
endmodule

// File: tb/tb_cos_job_issuer.sv
// tb_cos_job_issuer: directed self-checking bench for cos_job_issuer
module tb_cos_job_issuer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [9:0] req_x = '0;
    logic [7:0] req_y = '0;
    logic       req_ready;
    logic       core_start;
    logic [9:0] core_x;
    logic [7:0] core_y;
    logic       core_ready;
    logic [9:0] core_result;
    logic       res_valid;
    logic [9:0] res_data;
    logic       res_ack = 1'b0;
    logic       busy;
    logic [7:0] done_count;
`ifdef COS_ISSUER_TIMEOUT_EN
    logic       res_err;
`endif
    int checks = 0;
    int errors = 0;
    int starts = 0;
    logic       m_ready = 1'b0;
    logic [9:0] m_res = '0;
    logic       m_run = 1'b0;
    int         m_cnt = 0;
    int         core_lat = 20;
    logic       manual = 1'b0;
    logic       man_ready = 1'b0;
    logic [9:0] man_res = '0;

    cos_job_issuer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_ready(req_ready), .core_start(core_start), .core_x(core_x), .core_y(core_y),
        .core_ready(core_ready), .core_result(core_result), .res_valid(res_valid),
        .res_data(res_data), .res_ack(res_ack), .busy(busy), .done_count(done_count)
`ifdef COS_ISSUER_TIMEOUT_EN
        , .res_err(res_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (core_start) starts++;

    // core model: result = x ^ (y * 0x55), ready after core_lat clocks, held until next start
    always @(posedge clk) begin
        if (core_start) begin
            m_run   <= 1'b1;
            m_cnt   <= core_lat;
            m_ready <= 1'b0;
        end else if (m_run) begin
            if (m_cnt <= 1) begin
                m_run   <= 1'b0;
                m_ready <= 1'b1;
                m_res   <= core_x ^ (10'(core_y) * 10'h055);
            end else m_cnt <= m_cnt - 1;
        end
    end
    assign core_ready  = manual ? man_ready : m_ready;
    assign core_result = manual ? man_res : m_res;

    task automatic wait_res(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, core_start, res_valid, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 1000", {req_ready, core_start, res_valid, busy});
        end
        checks++;
        if ({core_x, core_y, res_data, done_count} !== 36'h0) begin
            errors++;
            $display("FAIL reset_values got %h exp 0", {core_x, core_y, res_data, done_count});
        end
        rst = 1'b0;
    endtask

    task automatic test_single;
        bit ok;
        int s0;
        s0 = starts;
        req_valid = 1'b1; req_x = 10'h100; req_y = 8'd1;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (core_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_accept got start=%b busy=%b exp start=0 busy=1", core_start, busy);
        end
        @(negedge clk);
        checks++;
        if (core_start !== 1'b1 || core_x !== 10'h100 || core_y !== 8'd1) begin
            errors++;
            $display("FAIL single_issue got start=%b x=%h y=%h exp 1 100 01", core_start, core_x, core_y);
        end
        @(negedge clk);
        checks++;
        if (core_start !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse got start=%b exp 0", core_start);
        end
        wait_res(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_timeout got res_valid=0 exp 1");
        end
        checks++;
        if (res_data !== 10'h155 || done_count !== 8'd1 || starts - s0 != 1) begin
            errors++;
            $display("FAIL single_result got data=%h done=%0d starts=%0d exp 155 1 1", res_data, done_count, starts - s0);
        end
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_ack got valid=%b busy=%b exp 0 0", res_valid, busy);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        bit bad;
        int s0;
        core_lat = 5;
        req_valid = 1'b1; req_x = 10'h011; req_y = 8'd0;
        @(negedge clk);
        req_x = 10'h022; req_y = 8'd2;
        @(negedge clk);
        req_valid = 1'b0;
        res_ack = 1'b1;
        repeat (3) @(negedge clk);
        res_ack = 1'b0;
        wait_res(100, ok);
        checks++;
        if (!ok || res_data !== 10'h011 || done_count !== 8'd2) begin
            errors++;
            $display("FAIL bp_first got valid=%b data=%h done=%0d exp 1 011 2", res_valid, res_data, done_count);
        end
        s0 = starts;
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== 10'h011 || done_count !== 8'd2 || starts != s0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold got valid=%b data=%h done=%0d starts=%0d exp 1 011 2 %0d", res_valid, res_data, done_count, starts, s0);
        end
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        @(negedge clk);
        wait_res(100, ok);
        checks++;
        if (!ok || res_data !== 10'h088 || done_count !== 8'd3) begin
            errors++;
            $display("FAIL bp_second got valid=%b data=%h done=%0d exp 1 088 3", res_valid, res_data, done_count);
        end
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
    endtask

    task automatic test_fill;
        bit ok;
        logic [9:0] exp_res [5] = '{10'h054, 10'h057, 10'h056, 10'h051, 10'h050};
        core_lat = 30;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_x = 10'(i + 1); req_y = 8'd1;
            #1;
            checks++;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready_%0d got %b exp 1", i, req_ready);
            end
            @(negedge clk);
        end
        req_x = 10'h3FF; req_y = 8'hFF;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full got %b exp 0", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_res(200, ok);
            checks++;
            if (!ok || res_data !== exp_res[i]) begin
                errors++;
                $display("FAIL fill_order_%0d got valid=%b data=%h exp 1 %h", i, res_valid, res_data, exp_res[i]);
            end
            res_ack = 1'b1;
            @(negedge clk);
            res_ack = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0 || done_count !== 8'd8) begin
            errors++;
            $display("FAIL fill_drain got busy=%b done=%0d exp 0 8", busy, done_count);
        end
    endtask

    task automatic test_stale;
        bit bad;
        manual = 1'b1; man_ready = 1'b1; man_res = 10'h2A5;
        req_valid = 1'b1; req_x = 10'h0AA; req_y = 8'd3;
        @(negedge clk);
        req_valid = 1'b0;
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (res_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stale_capture got res_valid=1 exp 0");
        end
        man_ready = 1'b0;
        @(negedge clk);
        man_ready = 1'b1;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_low got res_valid=%b exp 0", res_valid);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 10'h2A5 || done_count !== 8'd9) begin
            errors++;
            $display("FAIL stale_rise got valid=%b data=%h done=%0d exp 1 2a5 9", res_valid, res_data, done_count);
        end
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
    endtask

    task automatic test_reset_wait;
        bit bad;
        manual = 1'b1; man_ready = 1'b0;
        req_valid = 1'b1; req_x = 10'h155; req_y = 8'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({res_valid, busy, req_ready, core_start} !== 4'b0010 || {core_x, core_y, res_data, done_count} !== 36'h0) begin
            errors++;
            $display("FAIL rst_async got flags=%b vals=%h exp 0010 0", {res_valid, busy, req_ready, core_start}, {core_x, core_y, res_data, done_count});
        end
        @(negedge clk);
        rst = 1'b0;
        man_ready = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || busy !== 1'b0 || done_count !== 8'd0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rst_abandon got valid=%b busy=%b done=%0d exp 0 0 0", res_valid, busy, done_count);
        end
        man_ready = 1'b0;
    endtask

`ifdef COS_ISSUER_TIMEOUT_EN
    task automatic test_timeout;
        manual = 1'b1; man_ready = 1'b0;
        req_valid = 1'b1; req_x = 10'h001; req_y = 8'd1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (core_start !== 1'b1) begin
            errors++;
            $display("FAIL tmo_start got %b exp 1", core_start);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL tmo_early got %b exp 0", res_valid);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 10'h3FF || res_err !== 1'b1 || done_count !== 8'd0) begin
            errors++;
            $display("FAIL tmo_hold got valid=%b data=%h err=%b done=%0d exp 1 3ff 1 0", res_valid, res_data, res_err, done_count);
        end
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_backpressure;
        test_fill;
        test_stale;
        test_reset_wait;
`ifdef COS_ISSUER_TIMEOUT_EN
        test_timeout;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
